// File: rtl/bpsk_pkg.sv
// Shared types, parity modes and parameter checks for the
// BPSK packet-to-UART bridge.
package bpsk_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } ser_state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   function automatic bit params_ok(
      input int pkt_bits,
      input int data_bits,
      input int depth,
      input int parity,
      input int stop_bits,
      input int msb_first
   );
      return (data_bits >= 5) && (data_bits <= 9)
          && (pkt_bits >= data_bits)
          && ((pkt_bits % data_bits) == 0)
          && (depth >= 2) && ((depth & (depth - 1)) == 0)
          && (parity >= PAR_NONE) && (parity <= PAR_ODD)
          && ((stop_bits == 1) || (stop_bits == 2))
          && ((msb_first == 0) || (msb_first == 1));
   endfunction

endpackage

// File: rtl/packet_fifo.sv
// Packet FIFO: power-of-two depth, show-ahead read data,
// push accepted when full if a pop happens in the same cycle.
module packet_fifo #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q;
   logic [AW-1:0]    rptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem_q[rptr_q];
   assign count   = count_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop) rptr_q <= rptr_q + 1'b1;
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wptr_q] <= wdata;
   end

endmodule

// File: rtl/bpsk_uart_bridge.sv
// Assembles demodulated bits into packets, queues them and
// streams each packet out as back-to-back UART frames.
module bpsk_uart_bridge
   import bpsk_pkg::*;
#(
   parameter  int PACKET_BITS = 32,
   parameter  int DATA_BITS   = 8,
   parameter  int FIFO_DEPTH  = 4,
   parameter  int PARITY      = 0,
   parameter  int STOP_BITS   = 1,
   parameter  int MSB_FIRST   = 1,
   localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          bit_data,
   input  logic          bit_valid,
   input  logic          resync,
   input  logic          baud_tick,
   output logic          tx,
   output logic          busy,
   output logic [CW-1:0] fifo_count,
   output logic          overflow,
   input  logic          overflow_clr
);

   localparam int WORDS = PACKET_BITS / DATA_BITS;
   localparam int BW    = $clog2(PACKET_BITS);
   localparam int WW    = $clog2(WORDS + 1);
   localparam int DW    = $clog2(DATA_BITS);

   if (!params_ok(PACKET_BITS, DATA_BITS, FIFO_DEPTH,
                  PARITY, STOP_BITS, MSB_FIRST)) begin : g_bad_params
      $error("bpsk_uart_bridge: illegal parameter set");
   end

   logic [BW-1:0]          acnt_q, acnt_d;
   logic [PACKET_BITS-1:0] shreg_q, shreg_d;
   logic                   ovf_q, ovf_d;
   logic                   pkt_done;
   logic                   fifo_full, fifo_empty, fifo_pop;
   logic [PACKET_BITS-1:0] fifo_rdata;

   ser_state_e             state_q, state_d;
   logic [PACKET_BITS-1:0] word_q, word_d;
   logic [WW-1:0]          wcnt_q, wcnt_d;
   logic [DW-1:0]          bit_q, bit_d;
   logic                   tx_q, tx_d;
   logic [DATA_BITS-1:0]   cur;
   logic                   par_bit;

   // resync and a same-cycle bit: that bit becomes bit 0
   always_comb begin
      acnt_d   = resync ? '0 : acnt_q;
      shreg_d  = shreg_q;
      pkt_done = 1'b0;
      if (bit_valid) begin
         shreg_d = (MSB_FIRST != 0)
                 ? {shreg_q[PACKET_BITS-2:0], bit_data}
                 : {bit_data, shreg_q[PACKET_BITS-1:1]};
         if (acnt_d == BW'(PACKET_BITS - 1)) begin
            acnt_d   = '0;
            pkt_done = 1'b1;
         end else begin
            acnt_d = acnt_d + 1'b1;
         end
      end
   end

   always_comb begin
      ovf_d = ovf_q;
      if (pkt_done && fifo_full && !fifo_pop) ovf_d = 1'b1;
      else if (overflow_clr) ovf_d = 1'b0;
   end

   packet_fifo #(
      .WIDTH (PACKET_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (pkt_done),
      .pop     (fifo_pop),
      .wdata   (shreg_d),
      .rdata   (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign cur     = word_q[PACKET_BITS-1 -: DATA_BITS];
   assign par_bit = (^cur) ^ (PARITY == PAR_ODD);

   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      wcnt_d   = wcnt_q;
      bit_d    = bit_q;
      tx_d     = tx_q;
      fifo_pop = 1'b0;
      if (baud_tick) begin
         unique case (state_q)
            S_IDLE: begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  word_d   = fifo_rdata;
                  wcnt_d   = '0;
                  state_d  = S_START;
                  tx_d     = 1'b0;
               end
            end
            S_START: begin
               state_d = S_DATA;
               bit_d   = '0;
               tx_d    = cur[0];
            end
            S_DATA: begin
               if (bit_q == DW'(DATA_BITS - 1)) begin
                  bit_d = '0;
                  if (PARITY != PAR_NONE) begin
                     state_d = S_PARITY;
                     tx_d    = par_bit;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
                  tx_d  = cur[bit_d];
               end
            end
            S_PARITY: begin
               state_d = S_STOP;
               tx_d    = 1'b1;
            end
            S_STOP: begin
               if (bit_q == DW'(STOP_BITS - 1)) begin
                  bit_d = '0;
                  if (wcnt_q != WW'(WORDS - 1)) begin
                     word_d  = word_q << DATA_BITS;
                     wcnt_d  = wcnt_q + 1'b1;
                     state_d = S_START;
                     tx_d    = 1'b0;
                  end else if (!fifo_empty) begin
                     fifo_pop = 1'b1;
                     word_d   = fifo_rdata;
                     wcnt_d   = '0;
                     state_d  = S_START;
                     tx_d     = 1'b0;
                  end else begin
                     state_d = S_IDLE;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         acnt_q  <= '0;
         shreg_q <= '0;
         ovf_q   <= 1'b0;
         state_q <= S_IDLE;
         word_q  <= '0;
         wcnt_q  <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
      end else begin
         acnt_q  <= acnt_d;
         shreg_q <= shreg_d;
         ovf_q   <= ovf_d;
         state_q <= state_d;
         word_q  <= word_d;
         wcnt_q  <= wcnt_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
      end
   end

   assign tx       = tx_q;
   assign busy     = (state_q != S_IDLE);
   assign overflow = ovf_q;

endmodule

// File: tb/tb_bpsk_uart_bridge.sv
// Bench for bpsk_uart_bridge: three parameter sets share one
// stimulus; the line is decoded back into words per instance.
module tb_bpsk_uart_bridge;

   logic clock, reset_n;
   logic bit_data, bit_valid, resync, baud_tick, overflow_clr;
   logic tx[3], busy[3], ovf[3];
   logic [2:0] cnt0, cnt2;
   logic [1:0] cnt1;

   int checks = 0;
   int failures = 0;
   int tick_en = 0;
   int tick_num = 4;

   int PAR[3] = '{0, 1, 2};
   int SB[3]  = '{1, 1, 2};

   bit samp[3][$];
   int dw[3][$];
   bit dp[3][$];
   int derr[3];
   int ew[3][$];
   bit bl16[$];
   bit bl8[$];

   typedef struct {
      logic [15:0] pkt;
      logic [7:0]  u2w0;
      logic [7:0]  u2w1;
      logic        u1p0;
      logic        u1p1;
      logic        u2p0;
      logic        u2p1;
   } vec_t;
   vec_t vt[5];

   bpsk_uart_bridge #(
      .PACKET_BITS(16), .DATA_BITS(8), .FIFO_DEPTH(4),
      .PARITY(0), .STOP_BITS(1), .MSB_FIRST(1)
   ) u0 (
      .clock(clock), .reset_n(reset_n), .bit_data(bit_data),
      .bit_valid(bit_valid), .resync(resync), .baud_tick(baud_tick),
      .tx(tx[0]), .busy(busy[0]), .fifo_count(cnt0),
      .overflow(ovf[0]), .overflow_clr(overflow_clr)
   );

   bpsk_uart_bridge #(
      .PACKET_BITS(16), .DATA_BITS(8), .FIFO_DEPTH(2),
      .PARITY(1), .STOP_BITS(1), .MSB_FIRST(1)
   ) u1 (
      .clock(clock), .reset_n(reset_n), .bit_data(bit_data),
      .bit_valid(bit_valid), .resync(resync), .baud_tick(baud_tick),
      .tx(tx[1]), .busy(busy[1]), .fifo_count(cnt1),
      .overflow(ovf[1]), .overflow_clr(overflow_clr)
   );

   bpsk_uart_bridge #(
      .PACKET_BITS(8), .DATA_BITS(8), .FIFO_DEPTH(4),
      .PARITY(2), .STOP_BITS(2), .MSB_FIRST(0)
   ) u2 (
      .clock(clock), .reset_n(reset_n), .bit_data(bit_data),
      .bit_valid(bit_valid), .resync(resync), .baud_tick(baud_tick),
      .tx(tx[2]), .busy(busy[2]), .fifo_count(cnt2),
      .overflow(ovf[2]), .overflow_clr(overflow_clr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One line sample per baud period, taken after the tick's edge
   initial begin
      baud_tick = 1'b0;
      forever begin
         @(negedge clock);
         if (baud_tick) begin
            for (int k = 0; k < 3; k++) samp[k].push_back(tx[k]);
         end
         baud_tick = (tick_en != 0) &&
                     (int'($urandom_range(0, 3)) < tick_num);
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic int cnt(input int k);
      case (k)
         0: return int'(cnt0);
         1: return int'(cnt1);
         default: return int'(cnt2);
      endcase
   endfunction

   function automatic int exp_par(input int k, input int w);
      logic [7:0] b;
      b = w[7:0];
      return int'((^b) ^ (PAR[k] == 2));
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic int getw(input int k, input int i);
      if (i < dw[k].size()) return dw[k][i];
      return -1;
   endfunction

   function automatic int getp(input int k, input int i);
      if (i < dp[k].size()) return int'(dp[k][i]);
      return -1;
   endfunction

   // Packets form from plain bit lists; words follow slice order
   task automatic model_bit(input bit b, input bit v, input bit rs);
      int p;
      if (rs) begin
         bl16.delete();
         bl8.delete();
      end
      if (v) begin
         bl16.push_back(b);
         bl8.push_back(b);
         if (bl16.size() == 16) begin
            p = 0;
            for (int i = 0; i < 16; i++) p = p * 2 + int'(bl16[i]);
            for (int k = 0; k < 2; k++) begin
               ew[k].push_back(p / 256);
               ew[k].push_back(p % 256);
            end
            bl16.delete();
         end
         if (bl8.size() == 8) begin
            p = 0;
            for (int i = 0; i < 8; i++) p += int'(bl8[i]) << i;
            ew[2].push_back(p);
            bl8.delete();
         end
      end
   endtask

   task automatic clear_all();
      bl16.delete();
      bl8.delete();
      for (int k = 0; k < 3; k++) begin
         ew[k].delete();
         samp[k].delete();
      end
   endtask

   task automatic drive(input bit b, input bit v, input bit rs, input bit clr);
      bit_data = b;
      bit_valid = v;
      resync = rs;
      overflow_clr = clr;
      model_bit(b, v, rs);
      @(negedge clock);
      bit_data = 1'b0;
      bit_valid = 1'b0;
      resync = 1'b0;
      overflow_clr = 1'b0;
   endtask

   task automatic send_pkt(input logic [15:0] p, input bit clr_last);
      for (int i = 15; i >= 0; i--) drive(p[i], 1'b1, 1'b0, clr_last && (i == 0));
   endtask

   task automatic do_reset();
      tick_en = 0;
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      clear_all();
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((busy[0] || busy[1] || busy[2] || cnt(0) != 0 ||
              cnt(1) != 0 || cnt(2) != 0) && t < 3000) begin
         @(negedge clock);
         t++;
      end
      if (t >= 3000) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: actual=%0d required<%0d", t, 3000);
      end
      repeat (4) @(negedge clock);
   endtask

   task automatic decode(input int k);
      int i, n, w, np;
      dw[k].delete();
      dp[k].delete();
      derr[k] = 0;
      np = (PAR[k] != 0) ? 1 : 0;
      n = samp[k].size();
      i = 0;
      while (i < n) begin
         if (samp[k][i]) begin
            i++;
         end else begin
            if (i + 9 + np + SB[k] > n) begin
               derr[k]++;
               break;
            end
            w = 0;
            for (int j = 0; j < 8; j++) w |= int'(samp[k][i+1+j]) << j;
            dw[k].push_back(w);
            if (np != 0) dp[k].push_back(samp[k][i+9]);
            for (int j = 0; j < SB[k]; j++)
               if (!samp[k][i+9+np+j]) derr[k]++;
            i += 9 + np + SB[k];
         end
      end
   endtask

   task automatic check_model(input int k, input string tag);
      int n;
      decode(k);
      chk($sformatf("%s_u%0d_nwords", tag, k), dw[k].size(), ew[k].size());
      chk($sformatf("%s_u%0d_framing", tag, k), derr[k], 0);
      n = (dw[k].size() < ew[k].size()) ? dw[k].size() : ew[k].size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_u%0d_word%0d", tag, k, i), dw[k][i], ew[k][i]);
         if (PAR[k] != 0)
            chk($sformatf("%s_u%0d_par%0d", tag, k, i), getp(k, i),
                exp_par(k, ew[k][i]));
      end
   endtask

   function automatic int first_zero(input int k);
      for (int i = 0; i < samp[k].size(); i++)
         if (!samp[k][i]) return i;
      return -1;
   endfunction

   initial begin
      bit exp1[20];
      bit exp5[24];
      bit b, rs, v;
      int f, z, t;
      logic [15:0] rp;

      vt[0] = '{16'hA55A, 8'hA5, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1};
      vt[1] = '{16'h0007, 8'h00, 8'hE0, 1'b0, 1'b1, 1'b1, 1'b0};
      vt[2] = '{16'h8001, 8'h01, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[3] = '{16'hFFFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1};
      vt[4] = '{16'h1234, 8'h48, 8'h2C, 1'b0, 1'b1, 1'b1, 1'b0};
      exp1 = '{0, 1,0,1,0,0,1,0,1, 1, 0, 0,1,0,1,1,0,1,0, 1};
      exp5 = '{0, 1,0,0,0,0,0,0,0, 0, 1,1,
               0, 1,1,1,0,0,0,0,0, 0, 1,1};

      bit_data = 1'b0;
      bit_valid = 1'b0;
      resync = 1'b0;
      overflow_clr = 1'b0;
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset_tx_u%0d", k), tx[k], 1);
         chk($sformatf("reset_busy_u%0d", k), busy[k], 0);
         chk($sformatf("reset_count_u%0d", k), cnt(k), 0);
         chk($sformatf("reset_ovf_u%0d", k), ovf[k], 0);
      end
      reset_n = 1'b1;
      @(negedge clock);
      clear_all();

      // Basic frames, exact line sequence on u0
      for (int i = 15; i >= 1; i--) drive(vt[0].pkt[i], 1'b1, 1'b0, 1'b0);
      chk("basic_count_before", cnt(0), 0);
      drive(vt[0].pkt[0], 1'b1, 1'b0, 1'b0);
      chk("basic_count_after", cnt(0), 1);
      chk("basic_busy_queued", busy[0], 0);
      tick_num = 4;
      tick_en = 1;
      drain();
      f = first_zero(0);
      chk("basic_start_found", int'(f >= 0), 1);
      if (f >= 0) begin
         for (int j = 0; j < 20; j++)
            chk($sformatf("basic_line%0d", j),
                (f + j < samp[0].size()) ? int'(samp[0][f+j]) : -1,
                int'(exp1[j]));
         z = 0;
         for (int j = f + 20; j < samp[0].size(); j++)
            if (!samp[0][j]) z++;
         chk("basic_idle_after", z, 0);
      end
      chk("basic_busy_end", busy[0], 0);

      // Table of packets, ticks every cycle
      for (int n = 0; n < 5; n++) begin
         for (int k = 0; k < 3; k++) samp[k].delete();
         send_pkt(vt[n].pkt, 1'b0);
         drain();
         for (int k = 0; k < 3; k++) begin
            decode(k);
            chk($sformatf("vec%0d_u%0d_nwords", n, k), dw[k].size(), 2);
            chk($sformatf("vec%0d_u%0d_framing", n, k), derr[k], 0);
         end
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("vec%0d_u%0d_w0", n, k), getw(k, 0), int'(vt[n].pkt[15:8]));
            chk($sformatf("vec%0d_u%0d_w1", n, k), getw(k, 1), int'(vt[n].pkt[7:0]));
         end
         chk($sformatf("vec%0d_u1_p0", n), getp(1, 0), int'(vt[n].u1p0));
         chk($sformatf("vec%0d_u1_p1", n), getp(1, 1), int'(vt[n].u1p1));
         chk($sformatf("vec%0d_u2_w0", n), getw(2, 0), int'(vt[n].u2w0));
         chk($sformatf("vec%0d_u2_w1", n), getw(2, 1), int'(vt[n].u2w1));
         chk($sformatf("vec%0d_u2_p0", n), getp(2, 0), int'(vt[n].u2p0));
         chk($sformatf("vec%0d_u2_p1", n), getp(2, 1), int'(vt[n].u2p1));
      end

      // Overflow on the depth-2 instance with ticks held low
      do_reset();
      send_pkt(16'hC3A1, 1'b0);
      send_pkt(16'h5E27, 1'b0);
      send_pkt(16'h9B04, 1'b0);
      chk("ovf_u1_count", cnt(1), 2);
      chk("ovf_u1_flag", ovf[1], 1);
      chk("ovf_u0_count", cnt(0), 3);
      chk("ovf_u0_flag", ovf[0], 0);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      chk("ovf_u1_cleared", ovf[1], 0);
      send_pkt(16'h6DF0, 1'b1);
      chk("ovf_u1_set_wins", ovf[1], 1);
      chk("ovf_u1_count2", cnt(1), 2);
      chk("ovf_u0_count4", cnt(0), 4);
      ew[1].delete();
      ew[1].push_back(8'hC3);
      ew[1].push_back(8'hA1);
      ew[1].push_back(8'h5E);
      ew[1].push_back(8'h27);
      tick_num = 4;
      tick_en = 1;
      drain();
      check_model(0, "ovf");
      check_model(1, "ovf");

      // Resync with a bit in the same cycle
      do_reset();
      for (int i = 0; i < 5; i++) drive(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
      rp = 16'($urandom);
      drive(rp[15], 1'b1, 1'b1, 1'b0);
      for (int i = 14; i >= 0; i--) drive(rp[i], 1'b1, 1'b0, 1'b0);
      chk("resync_u0_count", cnt(0), 1);
      chk("resync_u2_count", cnt(2), 2);
      tick_en = 1;
      drain();
      check_model(0, "resync");
      check_model(1, "resync");
      check_model(2, "resync");
      chk("resync_u0_hi", getw(0, 0), int'(rp[15:8]));
      chk("resync_u0_lo", getw(0, 1), int'(rp[7:0]));

      // Reset in the middle of a data field
      do_reset();
      send_pkt(16'h0000, 1'b0);
      send_pkt(16'h0000, 1'b0);
      tick_num = 4;
      tick_en = 1;
      t = 0;
      while (!busy[0] && t < 100) begin
         @(negedge clock);
         t++;
      end
      chk("rst_busy_seen", busy[0], 1);
      repeat (3) @(negedge clock);
      chk("rst_pre_tx", tx[0], 0);
      #2 reset_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_async_tx_u%0d", k), tx[k], 1);
         chk($sformatf("rst_async_count_u%0d", k), cnt(k), 0);
         chk($sformatf("rst_async_busy_u%0d", k), busy[k], 0);
      end
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      clear_all();
      repeat (60) @(negedge clock);
      for (int k = 0; k < 3; k++) begin
         z = 0;
         foreach (samp[k][j]) if (!samp[k][j]) z++;
         chk($sformatf("rst_quiet_u%0d", k), z, 0);
         chk($sformatf("rst_quiet_busy_u%0d", k), busy[k], 0);
      end
      send_pkt(16'hA55A, 1'b0);
      drain();
      for (int k = 0; k < 3; k++) check_model(k, "rst_after");

      // LSB-first packets, odd parity, two stop bits back to back
      do_reset();
      for (int i = 0; i < 8; i++) drive(i == 0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) drive(i < 3, 1'b1, 1'b0, 1'b0);
      chk("lsb_u2_count", cnt(2), 2);
      tick_num = 4;
      tick_en = 1;
      drain();
      f = first_zero(2);
      chk("lsb_start_found", int'(f >= 0), 1);
      if (f >= 0) begin
         for (int j = 0; j < 24; j++)
            chk($sformatf("lsb_line%0d", j),
                (f + j < samp[2].size()) ? int'(samp[2][f+j]) : -1,
                int'(exp5[j]));
      end
      check_model(2, "lsb");
      chk("lsb_w0", getw(2, 0), 8'h01);
      chk("lsb_w1", getw(2, 1), 8'h07);
      check_model(0, "lsb");
      check_model(1, "lsb");

      // Randomised bits, resyncs and sparse ticks against the model
      do_reset();
      tick_num = 3;
      tick_en = 1;
      for (int n = 0; n < 600; n++) begin
         repeat ($urandom_range(1, 4)) @(negedge clock);
         rs = ($urandom_range(0, 49) == 0);
         v = rs ? 1'($urandom_range(0, 1)) : 1'b1;
         b = 1'($urandom_range(0, 1));
         drive(b, v, rs, 1'b0);
      end
      tick_num = 4;
      drain();
      for (int k = 0; k < 3; k++) begin
         check_model(k, "rand");
         chk($sformatf("rand_ovf_u%0d", k), ovf[k], 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
